// File: rtl/de0_pkg.sv
// rtl/de0_pkg.sv - shared types and default constants for the DE0 clock/reset sequencer
package de0_pkg;

    typedef enum logic [1:0] {
        S_PRST = 2'd0,
        S_WAIT = 2'd1,
        S_STAB = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    // turbo select codes, named by the resulting CPU rate at a 50 MHz clkin
    typedef enum logic [1:0] {
        T_3M5 = 2'd0,
        T_7M  = 2'd1,
        T_14M = 2'd2,
        T_25M = 2'd3
    } turbo_t;

    localparam int unsigned STEP0_DEF = 4588;
    localparam int unsigned STEP1_DEF = 9175;
    localparam int unsigned STEP2_DEF = 18350;
    localparam int unsigned STEP3_DEF = 32768;

endpackage

// File: rtl/de0_clk_seq_if.sv
// rtl/de0_clk_seq_if.sv - board/core-facing signal bundle of the clock/reset sequencer
interface de0_clk_seq_if;

    logic       locked;
    logic [1:0] turbo;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       cpu_ce;
    logic [7:0] retries;

    modport master (
        input  locked,
        input  turbo,
        output pll_rst,
        output sys_rst,
        output ready,
        output cpu_ce,
        output retries
    );

    modport slave (
        output locked,
        output turbo,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  cpu_ce,
        input  retries
    );

endinterface

// File: rtl/sync2ff.sv
// rtl/sync2ff.sv - two-flop synchronizer with asynchronous active-high clear
module sync2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/de0_clk_seq.sv
// rtl/de0_clk_seq.sv - PLL start-up/reset sequencer and turbo-selectable Z80 clock-enable
module de0_clk_seq
    import de0_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC  = 16,
    parameter int unsigned LOCK_TIMEOUT = 1048576,
    parameter int unsigned STABLE_CYC   = 65536,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned ACC_W        = 16,
    parameter int unsigned STEP0        = STEP0_DEF,
    parameter int unsigned STEP1        = STEP1_DEF,
    parameter int unsigned STEP2        = STEP2_DEF,
    parameter int unsigned STEP3        = STEP3_DEF
) (
    input  logic          clkin,
    input  logic          rst,
    de0_clk_seq_if.master bus
);

    localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYC - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       retries_q, retries_n;
    logic             pll_rst_q, sys_rst_q, ready_q, cpu_ce_q;
    logic             lk;
    logic             bump;

    logic [ACC_W-1:0] acc, step;
    logic [ACC_W:0]   sum;

    sync2ff u_lock_sync (
        .clk (clkin),
        .rst (rst),
        .d   (bus.locked),
        .q   (lk)
    );

    // lk is tested before the counter terminal value so a lock edge is never lost to a timeout
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        bump      = 1'b0;
        retries_n = retries_q;
        case (state)
            S_PRST: begin
                if (cnt == PRST_LAST) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (lk) begin
                    state_n = S_STAB;
                end else if (cnt == WAIT_LAST) begin
                    state_n = S_PRST;
                    bump    = 1'b1;
                end
            end
            S_STAB: begin
                if (!lk)                    state_n = S_WAIT;
                else if (cnt == STAB_LAST)  state_n = S_RUN;
            end
            S_RUN: begin
                cnt_n = cnt;
                if (!lk) begin
                    state_n = S_PRST;
                    bump    = 1'b1;
                end
            end
            default: state_n = S_PRST;
        endcase
        if (state_n != state) cnt_n = '0;
        if (bump && retries_q != 8'hFF) retries_n = retries_q + 8'd1;
    end

    // outputs decode the next state so they switch on the same edge as the state register
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state     <= S_PRST;
            cnt       <= '0;
            retries_q <= 8'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retries_q <= retries_n;
            pll_rst_q <= (state_n == S_PRST);
            sys_rst_q <= (state_n != S_RUN);
            ready_q   <= (state_n == S_RUN);
        end
    end

    always_comb begin
        step = ACC_W'(STEP0);
        case (turbo_t'(bus.turbo))
            T_3M5:   step = ACC_W'(STEP0);
            T_7M:    step = ACC_W'(STEP1);
            T_14M:   step = ACC_W'(STEP2);
            T_25M:   step = ACC_W'(STEP3);
            default: step = ACC_W'(STEP0);
        endcase
    end

    assign sum = {1'b0, acc} + {1'b0, step};

    // accumulator carry is the enable; acc keeps its phase across turbo changes
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cpu_ce_q <= 1'b0;
        end else if (state == S_RUN) begin
            {cpu_ce_q, acc} <= sum;
        end else begin
            acc      <= '0;
            cpu_ce_q <= 1'b0;
        end
    end

    assign bus.pll_rst = pll_rst_q;
    assign bus.sys_rst = sys_rst_q;
    assign bus.ready   = ready_q;
    assign bus.cpu_ce  = cpu_ce_q;
    assign bus.retries = retries_q;

endmodule
